// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: overflow-mode encoding,
// default geometry and the select-width helper.
package perf_pkg;

  localparam int WRAP = 0;
  localparam int SAT  = 1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

  // A single channel still needs a 1-bit select port.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One event counter with its snapshot shadow register and sticky overflow flag.
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = WRAP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    // Shadow takes the pre-edge count, so a same-cycle clear or increment is not seen.
    if (snap_i) shadow_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        if (SAT_MODE == WRAP) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with global snapshot, sticky overflow flags
// and a registered live/shadow readout port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = WRAP,
  localparam int SEL_W   = sel_w(NUM_CH)
) (
  input  logic              in_CLK,
  input  logic              in_RST,
  input  logic              EN,
  input  logic [NUM_CH-1:0] ev,
  input  logic              clr,
  input  logic              snap,
  input  logic [SEL_W-1:0]  sel,
  input  logic              rd_shadow,
  output logic [CNT_W-1:0]  data_out,
  output logic [NUM_CH-1:0] ovf,
  output logic              snap_valid
);

  logic [CNT_W-1:0] cnt_arr [NUM_CH];
  logic [CNT_W-1:0] shd_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_counter_ch #(
      .CNT_W   (CNT_W),
      .SAT_MODE(SAT_MODE)
    ) u_ch (
      .clk_i   (in_CLK),
      .rst_ni  (in_RST),
      .inc_i   (EN & ev[g]),
      .clr_i   (clr),
      .snap_i  (snap),
      .cnt_o   (cnt_arr[g]),
      .shadow_o(shd_arr[g]),
      .ovf_o   (ovf[g])
    );
  end

  logic [CNT_W-1:0] data_out_q, data_out_d;
  logic             snap_valid_q, snap_valid_d;

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    data_out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) data_out_d = rd_shadow ? shd_arr[i] : cnt_arr[i];
    end
  end

  assign snap_valid_d = snap | (snap_valid_q & ~clr);

  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      data_out_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: four bank configurations share one stimulus stream and are
// checked against an arithmetic reference model of the counting rules.
module tb_perf_counter_bank;

  localparam int NCFG = 4;

  logic       in_CLK = 1'b0;
  logic       in_RST = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] ev = '0;
  logic       clr = 1'b0;
  logic       snap = 1'b0;
  logic [1:0] sel = '0;
  logic       rd_shadow = 1'b0;

  logic [31:0] do0;
  logic [7:0]  do1, do2;
  logic [15:0] do3;
  logic [3:0]  ov0, ov1, ov2;
  logic [2:0]  ov3;
  logic        sv0, sv1, sv2, sv3;

  always #5 in_CLK = ~in_CLK;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SAT_MODE(0)) u_dut_w32 (
    .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .ev(ev), .clr(clr), .snap(snap),
    .sel(sel), .rd_shadow(rd_shadow), .data_out(do0), .ovf(ov0), .snap_valid(sv0));
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0)) u_dut_wrap8 (
    .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .ev(ev), .clr(clr), .snap(snap),
    .sel(sel), .rd_shadow(rd_shadow), .data_out(do1), .ovf(ov1), .snap_valid(sv1));
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1)) u_dut_sat8 (
    .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .ev(ev), .clr(clr), .snap(snap),
    .sel(sel), .rd_shadow(rd_shadow), .data_out(do2), .ovf(ov2), .snap_valid(sv2));
  perf_counter_bank #(.NUM_CH(3), .CNT_W(16), .SAT_MODE(0)) u_dut_nc3 (
    .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .ev(ev[2:0]), .clr(clr), .snap(snap),
    .sel(sel), .rd_shadow(rd_shadow), .data_out(do3), .ovf(ov3), .snap_valid(sv3));

  int cfg_nch [NCFG] = '{4, 4, 4, 3};
  int cfg_w   [NCFG] = '{32, 8, 8, 16};
  bit cfg_sat [NCFG] = '{0, 0, 1, 0};

  typedef struct packed {
    logic [3:0][63:0] dout;
    logic [3:0][3:0]  ovf;
    logic [3:0]       sv;
  } exp_t;

  exp_t exp_q[$];

  longint unsigned m_cnt [NCFG][4];
  longint unsigned m_shd [NCFG][4];
  bit              m_ovf [NCFG][4];
  bit              m_sv  [NCFG];

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  // Reference: one call models one clock edge with the given inputs.
  task automatic step(input bit rst, input bit en, input logic [3:0] e, input bit c,
                      input bit s, input logic [1:0] sl, input bit rs);
    exp_t x;
    longint unsigned maxv;
    @(negedge in_CLK);
    in_RST = rst; EN = en; ev = e; clr = c; snap = s; sel = sl; rd_shadow = rs;
    x = '0;
    for (int k = 0; k < NCFG; k++) begin
      maxv = (64'd1 << cfg_w[k]) - 64'd1;
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          m_cnt[k][i] = 0; m_shd[k][i] = 0; m_ovf[k][i] = 0;
        end
        m_sv[k] = 0;
        x.dout[k] = '0;
      end else begin
        if (int'(sl) >= cfg_nch[k]) x.dout[k] = '0;
        else x.dout[k] = rs ? m_shd[k][sl] : m_cnt[k][sl];
        for (int i = 0; i < cfg_nch[k]; i++) begin
          if (s) m_shd[k][i] = m_cnt[k][i];
          if (c) begin
            m_cnt[k][i] = 0;
            m_ovf[k][i] = 0;
          end else if (en && e[i]) begin
            if (m_cnt[k][i] == maxv) begin
              m_ovf[k][i] = 1;
              if (!cfg_sat[k]) m_cnt[k][i] = 0;
            end else begin
              m_cnt[k][i] = m_cnt[k][i] + 1;
            end
          end
        end
        if (c) m_sv[k] = s;
        else if (s) m_sv[k] = 1;
      end
      for (int i = 0; i < 4; i++) x.ovf[k][i] = m_ovf[k][i];
      x.sv[k] = m_sv[k];
    end
    exp_q.push_back(x);
  endtask

  task automatic run_ev(input int n, input logic [3:0] e);
    for (int j = 0; j < n; j++) step(1, 1, e, 0, 0, 2'd0, 0);
  endtask

  task automatic rd(input logic [1:0] sl, input bit rs);
    step(1, 1, 4'b0000, 0, 0, sl, rs);
  endtask

  // Monitor: every edge after stimulus starts presents a readout to check.
  initial begin : monitor
    exp_t x;
    logic [3:0][63:0] act_d;
    logic [3:0][3:0]  act_o;
    logic [3:0]       act_s;
    while (!done) begin
      @(posedge in_CLK);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        act_d = {64'(do3), 64'(do2), 64'(do1), 64'(do0)};
        act_o = {{1'b0, ov3}, ov2, ov1, ov0};
        act_s = {sv3, sv2, sv1, sv0};
        for (int k = 0; k < NCFG; k++) begin
          n_checks++;
          if (act_d[k] === x.dout[k]) n_pass++;
          else $display("FAIL data_out cfg%0d t=%0t: got %0d expected %0d", k, $time, act_d[k], x.dout[k]);
          n_checks++;
          if (act_o[k] === x.ovf[k]) n_pass++;
          else $display("FAIL ovf cfg%0d t=%0t: got %b expected %b", k, $time, act_o[k], x.ovf[k]);
          n_checks++;
          if (act_s[k] === x.sv[k]) n_pass++;
          else $display("FAIL snap_valid cfg%0d t=%0t: got %b expected %b", k, $time, act_s[k], x.sv[k]);
        end
      end
    end
  end

  initial begin : stim
    for (int k = 0; k < NCFG; k++) begin
      m_sv[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0; m_shd[k][i] = 0; m_ovf[k][i] = 0;
      end
    end
    // Reset with everything else active: reset must win.
    step(0, 1, 4'b1111, 1, 1, 2'd0, 0);
    step(0, 1, 4'b1111, 0, 1, 2'd1, 1);
    step(0, 0, 4'b0000, 0, 0, 2'd0, 0);

    run_ev(10, 4'b0001);
    for (int i = 0; i < 4; i++) rd(2'(i), 0);

    step(1, 1, 4'b0000, 1, 0, 2'd0, 0);
    run_ev(256, 4'b0100);
    rd(2'd2, 0);
    run_ev(3, 4'b0100);
    rd(2'd2, 0);
    rd(2'd2, 0);

    step(1, 1, 4'b0000, 1, 0, 2'd0, 0);
    run_ev(300, 4'b0010);
    rd(2'd1, 0);
    rd(2'd1, 0);

    step(1, 1, 4'b0000, 1, 0, 2'd0, 0);
    run_ev(7, 4'b0001);
    step(1, 1, 4'b0001, 1, 1, 2'd0, 0);
    rd(2'd0, 1);
    rd(2'd0, 0);
    rd(2'd0, 0);

    for (int j = 0; j < 5; j++) step(1, 0, 4'b1111, 0, 0, 2'd0, 0);
    step(1, 0, 4'b1111, 0, 1, 2'd3, 0);
    step(1, 0, 4'b1111, 0, 0, 2'd3, 1);
    step(1, 0, 4'b0000, 0, 0, 2'd3, 1);
    rd(2'd0, 1);

    step(1, 1, 4'b0000, 1, 0, 2'd0, 0);
    run_ev(100, 4'b1000);
    step(1, 1, 4'b0000, 0, 1, 2'd3, 0);
    step(0, 1, 4'b1111, 1, 1, 2'd3, 0);
    step(1, 1, 4'b1000, 0, 0, 2'd3, 0);
    rd(2'd3, 0);
    rd(2'd3, 0);
    rd(2'd3, 1);

    for (int j = 0; j < 2500; j++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) != 0),
           4'($urandom),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) == 0),
           2'($urandom),
           1'($urandom));
    end

    repeat (4) @(posedge in_CLK);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
